gpio_amm_master: RTL and testbench

//  Avalon-MM initiator that drives the register port of the GPIO controllers.

---
 rtl/gpio_amm_master.sv | 173 +++++++++++++++++
 tb/tb_gpio_amm_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_amm_master.sv
// Avalon-MM initiator for the GPIO register port: one host command in, one
// Avalon-MM transfer out, one response back, with a hung-slave timeout.
module gpio_amm_master #(
    parameter int AMM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_address_i,
    input  logic [AMM_WIDTH-1:0]  cmd_writedata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [AMM_WIDTH-1:0]  rsp_readdata_o,
    output logic                  rsp_error_o,
    output logic [ADDR_WIDTH-1:0] amm_address_o,
    output logic                  amm_write_o,
    output logic                  amm_read_o,
    output logic [AMM_WIDTH-1:0]  amm_writedata_o,
    input  logic                  amm_waitrequest_i,
    input  logic [AMM_WIDTH-1:0]  amm_readdata_i,
    input  logic                  amm_readdatavalid_i
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RSP     = 3'd4
    } state_t;

    state_t                  state_r;
    logic                    ready_r;
    logic                    amm_wr_r;
    logic                    amm_rd_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [AMM_WIDTH-1:0]    wdata_r;
    logic                    rsp_valid_r;
    logic                    rsp_err_r;
    logic [AMM_WIDTH-1:0]    rsp_data_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W:0]          cnt_inc_s;
    logic                    timeout_hit_s;

    assign cmd_ready_o     = ready_r;
    assign amm_write_o     = amm_wr_r;
    assign amm_read_o      = amm_rd_r;
    assign amm_address_o   = addr_r;
    assign amm_writedata_o = wdata_r;
    assign rsp_valid_o     = rsp_valid_r;
    assign rsp_error_o     = rsp_err_r;
    assign rsp_readdata_o  = rsp_data_r;

    // Flag the busy cycle that would use up the timeout budget
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        if (TIMEOUT > 0) begin
            timeout_hit_s = (cnt_inc_s == TIMEOUT_VAL);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer sequencer; completion is tested before the timeout so it wins a tie
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            amm_wr_r    <= 1'b0;
            amm_rd_r    <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i && ready_r) begin
                        ready_r <= 1'b0;
                        addr_r  <= cmd_address_i;
                        wdata_r <= cmd_writedata_i;
                        cnt_r   <= '0;
                        if (cmd_write_i) begin
                            amm_wr_r <= 1'b1;
                            state_r  <= ST_WR;
                        end else begin
                            amm_rd_r <= 1'b1;
                            state_r  <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (!amm_waitrequest_i) begin
                        amm_wr_r    <= 1'b0;
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else if (timeout_hit_s) begin
                        amm_wr_r    <= 1'b0;
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else begin
                        cnt_r <= cnt_inc_s[CNT_W-1:0];
                    end
                end
                ST_RD: begin
                    if (!amm_waitrequest_i && amm_readdatavalid_i) begin
                        amm_rd_r    <= 1'b0;
                        rsp_data_r  <= amm_readdata_i;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else if (timeout_hit_s) begin
                        amm_rd_r    <= 1'b0;
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else if (!amm_waitrequest_i) begin
                        amm_rd_r <= 1'b0;
                        cnt_r    <= cnt_inc_s[CNT_W-1:0];
                        state_r  <= ST_RD_WAIT;
                    end else begin
                        cnt_r <= cnt_inc_s[CNT_W-1:0];
                    end
                end
                ST_RD_WAIT: begin
                    if (amm_readdatavalid_i) begin
                        rsp_data_r  <= amm_readdata_i;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else if (timeout_hit_s) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                    end else begin
                        cnt_r <= cnt_inc_s[CNT_W-1:0];
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        ready_r     <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    amm_wr_r    <= 1'b0;
                    amm_rd_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_amm_master.sv
// Bench for gpio_amm_master: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_gpio_amm_master;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [3:0] cmd_address = 4'h0;
    logic [7:0] cmd_writedata = 8'h00;
    logic       rsp_ready = 1'b0;
    logic       amm_waitrequest = 1'b0, amm_readdatavalid = 1'b0;
    logic [7:0] amm_readdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_error, amm_write, amm_read;
    logic [7:0] rsp_readdata, amm_writedata;
    logic [3:0] amm_address;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    gpio_amm_master #(.AMM_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_address_i(cmd_address), .cmd_writedata_i(cmd_writedata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_readdata_o(rsp_readdata), .rsp_error_o(rsp_error),
        .amm_address_o(amm_address), .amm_write_o(amm_write), .amm_read_o(amm_read),
        .amm_writedata_o(amm_writedata), .amm_waitrequest_i(amm_waitrequest),
        .amm_readdata_i(amm_readdata), .amm_readdatavalid_i(amm_readdatavalid)
    );

    // Transaction view: a command is either idle, on the bus, awaiting data, or answered
    typedef struct packed {
        logic        ready;
        logic        wr_req;
        logic        rd_req;
        logic        awaiting;
        logic        rvalid;
        logic        err;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int unsigned age;
    } model_t;

    model_t mdl;

    function automatic model_t model_next(model_t c);
        model_t n;
        logic   done;
        n = c;
        done = 1'b0;
        if (c.rvalid) begin
            if (rsp_ready) begin
                n.rvalid = 1'b0;
                n.ready  = 1'b1;
            end
        end else if (c.ready) begin
            if (cmd_valid) begin
                n.ready  = 1'b0;
                n.addr   = cmd_address;
                n.wdata  = cmd_writedata;
                n.wr_req = cmd_write;
                n.rd_req = !cmd_write;
                n.age    = 0;
            end
        end else begin
            n.age = c.age + 1;
            if (c.wr_req && !amm_waitrequest) begin
                done = 1'b1;
                n.rdata = 8'h00;
            end else if (c.rd_req && !amm_waitrequest) begin
                n.rd_req = 1'b0;
                if (amm_readdatavalid) begin
                    done = 1'b1;
                    n.rdata = amm_readdata;
                end else begin
                    n.awaiting = 1'b1;
                end
            end else if (c.awaiting && amm_readdatavalid) begin
                done = 1'b1;
                n.rdata = amm_readdata;
            end
            if (done || n.age == TO) begin
                n.wr_req = 1'b0;
                n.rd_req = 1'b0;
                n.awaiting = 1'b0;
                n.rvalid = 1'b1;
                n.err = !done;
                if (!done) n.rdata = 8'h00;
            end
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    // Reference model advances on the same edges as the design
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) mdl <= model_reset();
        else        mdl <= model_next(mdl);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(mdl.ready));
            chk("amm_write", 32'(amm_write), 32'(mdl.wr_req));
            chk("amm_read", 32'(amm_read), 32'(mdl.rd_req));
            chk("rsp_valid", 32'(rsp_valid), 32'(mdl.rvalid));
            if (mdl.wr_req || mdl.rd_req) begin
                chk("amm_address", 32'(amm_address), 32'(mdl.addr));
            end
            if (mdl.wr_req) begin
                chk("amm_writedata", 32'(amm_writedata), 32'(mdl.wdata));
            end
            if (mdl.rvalid) begin
                chk("rsp_readdata", 32'(rsp_readdata), 32'(mdl.rdata));
                chk("rsp_error", 32'(rsp_error), 32'(mdl.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus(input int n);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        amm_waitrequest = 1'b0;
        amm_readdatavalid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int wr_cnt, rd_cnt, rsp_cnt, wait_pct;
        repeat (3) tick();
        chk("rst_amm_read", 32'(amm_read), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_readdata", 32'(rsp_readdata), 32'd0);
        rst_i = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'h1; cmd_writedata = 8'hA5;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("t1_write", 32'(amm_write), 32'd1);
        chk("t1_addr", 32'(amm_address), 32'h1);
        chk("t1_wdata", 32'(amm_writedata), 32'hA5);
        tick();
        chk("t1_write_drop", 32'(amm_write), 32'd0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_err", 32'(rsp_error), 32'd0);
        chk("t1_rsp_data", 32'(rsp_readdata), 32'h00);
        rsp_ready = 1'b1;
        tick();
        chk("t1_back_idle", 32'(cmd_ready), 32'd1);
        idle_bus(2);

        // 2: read with data three cycles after acceptance
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h2; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("t2_read", 32'(amm_read), 32'd1);
        tick();
        chk("t2_read_drop", 32'(amm_read), 32'd0);
        tick();
        tick();
        amm_readdatavalid = 1'b1; amm_readdata = 8'h5C;
        tick();
        amm_readdatavalid = 1'b0;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_data", 32'(rsp_readdata), 32'h5C);
        chk("t2_rsp_err", 32'(rsp_error), 32'd0);
        chk("t2_model_data", 32'(mdl.rdata), 32'h5C);
        idle_bus(3);

        // 3: write stalled by waitrequest for 5 cycles
        wr_cnt = 0; rsp_cnt = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'h9; cmd_writedata = 8'h3E;
        amm_waitrequest = 1'b1; rsp_ready = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) cmd_valid = 1'b0;
            if (i == 6) amm_waitrequest = 1'b0;
            if (amm_write) begin
                wr_cnt++;
                chk("t3_addr_stable", 32'(amm_address), 32'h9);
                chk("t3_data_stable", 32'(amm_writedata), 32'h3E);
            end
            if (rsp_valid) rsp_cnt++;
        end
        chk("t3_write_cycles", 32'(wr_cnt), 32'd6);
        chk("t3_responses", 32'(rsp_cnt), 32'd1);
        idle_bus(2);

        // 4: read timeout with waitrequest stuck high
        rd_cnt = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h3;
        amm_waitrequest = 1'b1; rsp_ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) cmd_valid = 1'b0;
            if (amm_read) rd_cnt++;
        end
        chk("t4_read_cycles", 32'(rd_cnt), 32'd8);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rsp_err", 32'(rsp_error), 32'd1);
        chk("t4_rsp_data", 32'(rsp_readdata), 32'h00);
        chk("t4_model_err", 32'(mdl.err), 32'd1);
        amm_readdatavalid = 1'b1; amm_readdata = 8'hAA;
        tick();
        chk("t4_late_data", 32'(rsp_readdata), 32'h00);
        amm_readdatavalid = 1'b0; rsp_ready = 1'b1; amm_waitrequest = 1'b0;
        tick();
        amm_readdatavalid = 1'b1;
        tick();
        tick();
        amm_readdatavalid = 1'b0;
        chk("t4_idle_ready", 32'(cmd_ready), 32'd1);
        chk("t4_idle_no_rsp", 32'(rsp_valid), 32'd0);
        idle_bus(2);

        // 5: zero-latency read skips the data wait
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h4; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0; amm_readdatavalid = 1'b1; amm_readdata = 8'h3C;
        tick();
        amm_readdatavalid = 1'b0;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_data", 32'(rsp_readdata), 32'h3C);
        chk("t5_read_drop", 32'(amm_read), 32'd0);
        idle_bus(2);

        // 6: held response, then reset during a data wait
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h5; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        amm_readdatavalid = 1'b1; amm_readdata = 8'h77;
        tick();
        amm_readdatavalid = 1'b0; amm_readdata = 8'h11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t6_hold_data", 32'(rsp_readdata), 32'h77);
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_address = 4'h6;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
        chk("t6_rst_read", 32'(amm_read), 32'd0);
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rst_addr", 32'(amm_address), 32'h0);
        chk("t6_rst_data", 32'(rsp_readdata), 32'h00);
        tick();
        tick();
        rst_i = 1'b1; amm_readdatavalid = 1'b1; amm_readdata = 8'h99;
        tick();
        amm_readdatavalid = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        chk("t6_no_rsp_after_rst", 32'(rsp_cnt), 32'd0);

        // Randomized traffic with varying slave stall density
        wait_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       wait_pct = 10;
                    1:       wait_pct = 40;
                    default: wait_pct = 90;
                endcase
            end
            cmd_valid         = ($urandom_range(0, 1) == 1);
            cmd_write         = ($urandom_range(0, 1) == 1);
            cmd_address       = 4'($urandom_range(0, 15));
            cmd_writedata     = 8'($urandom_range(0, 255));
            amm_waitrequest   = ($urandom_range(0, 99) < wait_pct);
            amm_readdatavalid = ($urandom_range(0, 99) < 30);
            amm_readdata      = 8'($urandom_range(0, 255));
            rsp_ready         = ($urandom_range(0, 99) < 60);
            rst_i             = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_i = 1'b1;
        idle_bus(30);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
